// File: rtl/f3_f4_pkg.sv
// Shared constants and types for the f3/f4 function unit and its built-in sweep self-test.
package f3_f4_pkg;

    localparam logic [15:0] F3_MASK   = 16'h30AA;
    localparam logic [15:0] F4_MASK   = 16'hA0AC;
    localparam int          SWEEP_LEN = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } sweep_state_t;

endpackage

// File: rtl/f3_f4_logic.sv
// Purely combinational f3/f4 evaluation of the 4-bit code {a,b,c,d}.
module f3_f4_logic (
    input  logic a,
    input  logic b,
    input  logic c,
    input  logic d,
    output logic f3,
    output logic f4
);

    assign f3 = (~a & d) | (a & b & ~c);
    assign f4 = (~a & ~b & c) | (b & d);

endmodule

// File: rtl/f3_f4.sv
// f3/f4 unit with a STAGES-deep output pipeline and an optional exhaustive self-test
// compiled in by the F3F4_SWEEP_EN macro.
module f3_f4
    import f3_f4_pkg::*;
#(
    parameter int STAGES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic first_in,
    input  logic second_in,
    input  logic third_in,
    input  logic fourth_in,
    input  logic in_valid,
    output logic out3,
    output logic out4,
    output logic out_valid,
    input  logic sweep_start,
    output logic sweep_busy,
    output logic sweep_done,
    output logic sweep_pass
);

    logic f3_comb;
    logic f4_comb;

    f3_f4_logic u_logic (
        .a  (first_in),
        .b  (second_in),
        .c  (third_in),
        .d  (fourth_in),
        .f3 (f3_comb),
        .f4 (f4_comb)
    );

    // Each stage holds {valid, f3, f4}; data loads every cycle regardless of valid.
    logic [2:0] pipe [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= {in_valid, f3_comb, f4_comb};
            for (int i = 1; i < STAGES; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign out_valid = pipe[STAGES-1][2];
    assign out3      = pipe[STAGES-1][1];
    assign out4      = pipe[STAGES-1][0];

`ifdef F3F4_SWEEP_EN
    sweep_state_t state;
    sweep_state_t state_next;
    logic [3:0]   cnt;
    logic [15:0]  sig3;
    logic [15:0]  sig4;
    logic         pass_q;
    logic         sweep_f3;
    logic         sweep_f4;

    // Independent instance so the sweep never touches the operand datapath.
    f3_f4_logic u_sweep_logic (
        .a  (cnt[3]),
        .b  (cnt[2]),
        .c  (cnt[1]),
        .d  (cnt[0]),
        .f3 (sweep_f3),
        .f4 (sweep_f4)
    );

    always_comb begin
        state_next = state;
        sweep_busy = 1'b0;
        sweep_done = 1'b0;
        case (state)
            S_IDLE: begin
                if (sweep_start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                sweep_busy = 1'b1;
                if (cnt == 4'(SWEEP_LEN - 1)) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                sweep_done = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            sig3   <= '0;
            sig4   <= '0;
            pass_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == S_RUN) begin
                cnt       <= cnt + 4'd1;
                sig3[cnt] <= sweep_f3;
                sig4[cnt] <= sweep_f4;
            end
            if (state == S_DONE) begin
                pass_q <= (sig3 == F3_MASK) && (sig4 == F4_MASK);
            end
        end
    end

    assign sweep_pass = pass_q;
`else
    logic unused_sweep_start;
    assign unused_sweep_start = sweep_start;
    assign sweep_busy         = 1'b0;
    assign sweep_done         = 1'b0;
    assign sweep_pass         = 1'b0;
`endif

endmodule

// File: tb/tb_f3_f4.sv
// Bench for f3_f4: one STAGES=1 and one STAGES=2 instance share the stimulus and are
// checked against minterm-list and cycle-count models of the specified behaviour.
module tb_f3_f4;

    logic clk;
    logic rst;
    logic first_in, second_in, third_in, fourth_in;
    logic in_valid;
    logic sweep_start;

    logic out3_1, out4_1, ov_1, busy_1, done_1, pass_1;
    logic out3_2, out4_2, ov_2, busy_2, done_2, pass_2;

    int tests = 0;
    int fails = 0;

    // history of {valid, code} one and two edges back
    logic [4:0] h1, h2;

    // sweep model: remaining RUN cycles, DONE pending, expected pass flag
    int   m_left;
    bit   m_done;
    bit   m_pass;

    f3_f4 #(.STAGES(1)) dut1 (
        .clk(clk), .rst(rst),
        .first_in(first_in), .second_in(second_in), .third_in(third_in), .fourth_in(fourth_in),
        .in_valid(in_valid),
        .out3(out3_1), .out4(out4_1), .out_valid(ov_1),
        .sweep_start(sweep_start),
        .sweep_busy(busy_1), .sweep_done(done_1), .sweep_pass(pass_1)
    );

    f3_f4 #(.STAGES(2)) dut2 (
        .clk(clk), .rst(rst),
        .first_in(first_in), .second_in(second_in), .third_in(third_in), .fourth_in(fourth_in),
        .in_valid(in_valid),
        .out3(out3_2), .out4(out4_2), .out_valid(ov_2),
        .sweep_start(sweep_start),
        .sweep_busy(busy_2), .sweep_done(done_2), .sweep_pass(pass_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic f3_ref(input int code);
        return code inside {1, 3, 5, 7, 12, 13};
    endfunction

    function automatic logic f4_ref(input int code);
        return code inside {2, 3, 5, 7, 13, 15};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        h1     = '0;
        h2     = '0;
        m_left = 0;
        m_done = 0;
        m_pass = 0;
    endtask

    task automatic check_sweep();
`ifdef F3F4_SWEEP_EN
        check("sweep_busy", busy_1, 16'(m_left > 0));
        check("sweep_done", done_1, 16'(m_done));
        check("sweep_pass", pass_1, 16'(m_pass));
        check("sweep_busy_s2", busy_2, 16'(m_left > 0));
        check("sweep_pass_s2", pass_2, 16'(m_pass));
`else
        check("sweep_busy_off", busy_1, 16'd0);
        check("sweep_done_off", done_1, 16'd0);
        check("sweep_pass_off", pass_1, 16'd0);
`endif
    endtask

    // Drive one code, clock once, advance the models and compare.
    task automatic cycle(input logic [3:0] code, input logic v, input logic start);
        {first_in, second_in, third_in, fourth_in} = code;
        in_valid    = v;
        sweep_start = start;
        @(posedge clk);
        #1;
        h2 = h1;
        h1 = {v, code};
        if (m_done) begin
            m_done = 0;
            m_pass = 1;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_done = 1;
        end else if (start) begin
            m_left = 16;
        end
        check("s1_valid", ov_1, 16'(h1[4]));
        if (h1[4]) begin
            check("s1_out3", out3_1, 16'(f3_ref(int'(h1[3:0]))));
            check("s1_out4", out4_1, 16'(f4_ref(int'(h1[3:0]))));
        end
        check("s2_valid", ov_2, 16'(h2[4]));
        if (h2[4]) begin
            check("s2_out3", out3_2, 16'(f3_ref(int'(h2[3:0]))));
            check("s2_out4", out4_2, 16'(f4_ref(int'(h2[3:0]))));
        end
        check_sweep();
    endtask

    task automatic random_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            cycle(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'b0);
        end
    endtask

    // Assert rst between clock edges and confirm outputs clear without a clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_out3"}, {out3_1, out3_2}, 16'd0);
        check({tag, "_out4"}, {out4_1, out4_2}, 16'd0);
        check({tag, "_valid"}, {ov_1, ov_2}, 16'd0);
        check({tag, "_busy"}, {busy_1, busy_2}, 16'd0);
        check({tag, "_done"}, {done_1, done_2}, 16'd0);
        model_clear();
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_sweep();
    endtask

    initial begin
        rst         = 1'b1;
        first_in    = 1'b0;
        second_in   = 1'b0;
        third_in    = 1'b0;
        fourth_in   = 1'b0;
        in_valid    = 1'b0;
        sweep_start = 1'b0;
        model_clear();
        #2;
        check("rst_out3", {out3_1, out3_2}, 16'd0);
        check("rst_out4", {out4_1, out4_2}, 16'd0);
        check("rst_valid", {ov_1, ov_2}, 16'd0);
        check("rst_busy", {busy_1, busy_2}, 16'd0);
        check("rst_done", {done_1, done_2}, 16'd0);
        check("rst_pass", {pass_1, pass_2}, 16'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // exhaustive back-to-back codes
        for (int i = 0; i < 16; i++) begin
            cycle(4'(i), 1'b1, 1'b0);
        end
        cycle(4'd0, 1'b0, 1'b0);

        cycle(4'b1100, 1'b1, 1'b0);
        check("c1100_out3", out3_1, 16'd1);
        check("c1100_out4", out4_1, 16'd0);
        cycle(4'b1111, 1'b1, 1'b0);
        check("c1111_out3", out3_1, 16'd0);
        check("c1111_out4", out4_1, 16'd1);
        cycle(4'b0011, 1'b1, 1'b0);
        check("c0011_out3", out3_1, 16'd1);
        check("c0011_out4", out4_1, 16'd1);
        cycle(4'd0, 1'b0, 1'b0);
        cycle(4'd0, 1'b0, 1'b0);

        // two-stage latency on a single valid pulse
        cycle(4'b0101, 1'b1, 1'b0);
        check("p2_early", ov_2, 16'd0);
        cycle(4'd0, 1'b0, 1'b0);
        check("p2_valid", ov_2, 16'd1);
        check("p2_out3", out3_2, 16'd1);
        check("p2_out4", out4_2, 16'd1);
        cycle(4'd0, 1'b0, 1'b0);
        check("p2_late", ov_2, 16'd0);

        random_cycles(40);

        // sweep with concurrent traffic and a second start while busy
        cycle(4'($urandom_range(15, 0)), 1'b1, 1'b1);
        for (int k = 0; k < 24; k++) begin
            cycle(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'(k == 5));
        end

        // sweep_start held for 20 cycles
        for (int k = 0; k < 20; k++) begin
            cycle(4'($urandom_range(15, 0)), 1'($urandom_range(1, 0)), 1'b1);
        end
        random_cycles(20);

        // abort a sweep at its seventh cycle, with live data in the pipeline
        cycle(4'($urandom_range(15, 0)), 1'b1, 1'b1);
        random_cycles(5);
        cycle(4'b0011, 1'b1, 1'b0);
        async_reset("mid_rst");
        random_cycles(20);

        // fresh sweep after reset
        cycle(4'($urandom_range(15, 0)), 1'b1, 1'b1);
        random_cycles(20);
`ifdef F3F4_SWEEP_EN
        check("final_pass", pass_1, 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/f3_f4.md
F3_F4 -- requirements
Module: f3_f4

Interface
- REQ-001 SHALL: parameter STAGES, default 1, output register depth; legal values 1 or 2.
- REQ-002 SHALL: clk  input  1  single clock; all state updates on rising edge.
- REQ-003 SHALL: rst  input  1  reset; asynchronous, active-high.
- REQ-004 SHALL: first_in  input  1  operand a, the MSB of the 4-bit code {a,b,c,d}.
- REQ-005 SHALL: second_in  input  1  operand b.
- REQ-006 SHALL: third_in  input  1  operand c.
- REQ-007 SHALL: fourth_in  input  1  operand d, the LSB.
- REQ-008 SHALL: in_valid  input  1  operands are valid this cycle.
- REQ-009 SHALL: out3  output  1  registered f3 result.
- REQ-010 SHALL: out4  output  1  registered f4 result.
- REQ-011 SHALL: out_valid  output  1  out3/out4 are valid.
- REQ-012 SHALL: sweep_start  input  1  requests a built-in exhaustive self-test.
- REQ-013 SHALL: sweep_busy, sweep_done, sweep_pass  output  1 each  self-test status.

Function
- REQ-014 SHALL: f3 = a'd + abc'; its minterms are 1,3,5,7,12,13, giving truth mask 16'h30AA, where bit i is f3(code i).
- REQ-015 SHALL: f4 = a'b'c + bd; its minterms are 2,3,5,7,13,15, giving truth mask 16'hA0AC.
- REQ-016 SHALL: f3 and f4 are computed combinationally from the current operands and then pass through STAGES register stages.
- REQ-017 SHALL: in_valid passes through the same STAGES registers to drive out_valid.
- REQ-018 SHALL: the output registers load every cycle regardless of in_valid; when out_valid=0, out3 and out4 hold don't-care data.
- REQ-019 SHALL: latency from operands to out3/out4 is exactly STAGES cycles, with throughput of one code per cycle.
- REQ-020 SHALL: the self-test FSM has states IDLE, RUN and DONE.
- REQ-021 SHALL: IDLE moves to RUN on sweep_start=1; sweep_start is ignored in RUN and DONE.
- REQ-022 SHALL: in RUN, a 4-bit counter steps from 0 to 15, one code per cycle, through a second, independent function instance; bit[cnt] of sig3 and sig4 captures f3/f4 of that code.
- REQ-023 SHALL: after code 15, RUN moves to DONE; DONE lasts one cycle and then returns to IDLE.
- REQ-024 SHALL: sweep_busy=1 in RUN, for exactly 16 cycles; sweep_done=1 only in DONE.
- REQ-025 SHALL: sweep_pass updates in DONE to (sig3==16'h30AA && sig4==16'hA0AC) and holds that value until the next DONE or reset.
- REQ-026 SHALL: the self-test never disturbs the main datapath; a sweep and normal operand traffic run concurrently.

Reset
- REQ-027 SHALL: rst=1 immediately clears all pipeline registers, so out3, out4 and out_valid are 0.
- REQ-028 SHALL: rst=1 returns the FSM to IDLE and clears the counter, sig3, sig4, sweep_busy, sweep_done and sweep_pass to 0.
- REQ-029 SHALL: reset in the middle of a sweep aborts it, and no sweep_done pulse is produced.

Configuration
- REQ-030 SHALL: macro F3F4_SWEEP_EN, when defined, compiles in the self-test (FSM, counter, signatures).
- REQ-031 SHALL: without F3F4_SWEEP_EN the sweep ports remain present; sweep_start is ignored and sweep_busy, sweep_done and sweep_pass are tied to 0.

Structure
- REQ-032 SHALL: package f3_f4_pkg holds F3_MASK=16'h30AA, F4_MASK=16'hA0AC, SWEEP_LEN=16 and the sweep state enum.
- REQ-033 SHALL: sub-module f3_f4_logic is a purely combinational block (a,b,c,d -> f3,f4), instanced once for the datapath and once for the self-test.

Verification
- REQ-034 SHALL: with rst=1 asserted asynchronously mid-cycle, out3, out4, out_valid and sweep_busy go to 0 at once, without waiting for clk.
- REQ-035 SHALL: STAGES=1, codes 0..15 applied with in_valid=1, one per cycle: each result matches the mask bit one cycle later; code 4'b1100 gives out3=1, out4=0; code 4'b1111 gives out3=0, out4=1; code 4'b0011 gives out3=1, out4=1.
- REQ-036 SHALL: STAGES=2, in_valid pulsed with code 4'b0101: out_valid pulses exactly 2 cycles later with out3=1, out4=1.
- REQ-037 SHALL: F3F4_SWEEP_EN defined, sweep_start pulse: sweep_busy is 1 for 16 cycles, then sweep_done pulses for 1 cycle, then sweep_pass=1; a second sweep_start while busy is ignored.
- REQ-038 SHALL: rst asserted at sweep cycle 7 leaves no sweep_done and sweep_pass=0; a new sweep after reset completes with sweep_pass=1.
- REQ-039 SHALL: F3F4_SWEEP_EN undefined, sweep_start=1 for 20 cycles: sweep_busy, sweep_done and sweep_pass stay 0 and the datapath is unaffected.
